multicycle_control: RTL
=======================

# multicycle_control

Multicycle main control unit for the 16-bit processor: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction, driving the datapath enables and the `ALUOp`/`funct` pair that the ALU control decoder consumes. It sits between the instruction register and the datapath, producing the codes the ALU control decoder translates into ALU operations. It also waits on a memory ready handshake and counts retired instructions.

## Interface
- `CNT_W`, 16: width of the retired-instruction counter.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 3: IR[15:13]. 000 R-type, 001 LW, 010 SW, 011 BEQ, 100 BNE, 101 ADDI, 110 J, 111 HALT.
- `funct_in` in 3: IR[2:0], R-type function field.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `i_or_d`, `reg_write`, `reg_dst`, `mem_to_reg`, `alu_src_a` out 1 each: datapath enables/selects.
- `alu_src_b` out 2: 00 regB, 01 const 1, 10 sign-ext imm, 11 sign-ext branch offset.
- `pc_source` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `alu_op` out 2: to ALU control decoder.
- `funct_out` out 3: to ALU control decoder.
- `halted` out 1: core stopped.
- `instr_count` out CNT_W: retired instructions.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC, ALU_WB, IMM_EXEC, IMM_WB, BRANCH, JUMP, HALT.
- All outputs default to 0 in every state. `funct_out` defaults to 000 unless a state sets it.
- FETCH:
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00.
  - `ir_write` and `pc_write` are asserted only while `mem_ready`=1.
  - Stays in FETCH while `mem_ready`=0. Goes to DECODE when it is 1.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 to precompute the branch target.
  - Next state: 000→EXEC, 001/010→MEM_ADDR, 011/100→BRANCH, 101→IMM_EXEC, 110→JUMP, 111→HALT.
- MEM_ADDR:
  - Drives `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Goes to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ:
  - Drives `mem_read`=1, `i_or_d`=1.
  - Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB:
  - Drives `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - Retires, then goes to FETCH.
- MEM_WRITE:
  - Drives `mem_write`=1, `i_or_d`=1.
  - Holds until `mem_ready`, then retires and goes to FETCH.
- EXEC:
  - Drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, `funct_out`=`funct_in`.
  - Goes to ALU_WB.
- ALU_WB:
  - Drives `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, and keeps `alu_op`=10, `funct_out`=`funct_in`.
  - Retires, then goes to FETCH.
- IMM_EXEC:
  - Drives `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11.
  - Goes to IMM_WB.
- IMM_WB:
  - Drives `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - Retires, then goes to FETCH.
- BRANCH:
  - Drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - `funct_out`=010 for BNE and 110 for BEQ.
  - Retires, then goes to FETCH.
- JUMP:
  - Drives `pc_write`=1, `pc_source`=10.
  - Retires, then goes to FETCH.
- HALT:
  - `halted`=1, no enables asserted.
  - Absorbing state; only `reset` leaves it. The HALT instruction itself is not counted.
- Retire: `instr_count` increments by 1 on the clock edge that leaves a retiring state. It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (asynchronous):
  - State returns to FETCH and `instr_count` clears to 0.
  - All control outputs follow FETCH decoding immediately: `mem_read`=1, `alu_src_b`=01, every other output 0, `halted`=0.
  - Reset mid-instruction or mid-wait abandons the instruction with no retire.
- Outputs are combinational from the state register. The only exception is FETCH `ir_write`/`pc_write`, which are also ANDed with `mem_ready`.
- Cycle counts with zero wait states:
  - R-type, ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, BNE, J: 3 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Control outputs are held stable throughout the wait.
- `mem_ready` asserted outside FETCH/MEM_READ/MEM_WRITE is ignored.
- `opcode`/`funct_in` are sampled from the IR and are stable from DECODE onward.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants.
  - ALUOp codes (00 mem/add, 01 branch, 10 R-type, 11 add-imm).
  - `alu_src_b` and `pc_source` encodings.
  - State enum.
- Sub-module `retire_counter`: CNT_W-bit wrapping counter with async active-high clear and an `inc` input.

## Test plan
- FETCH wait: R-type opcode 000, funct 011, `mem_ready` low 2 cycles in FETCH → stays in FETCH with `mem_read`=1 and `ir_write`=0, then DECODE, EXEC (`alu_op`=10, `funct_out`=011), ALU_WB; `instr_count` 0→1 after 6 cycles.
- Load: LW with `mem_ready` always 1 → 5 cycles; MEM_READ drives `i_or_d`=1, `mem_read`=1; MEM_WB drives `reg_write`=1, `mem_to_reg`=1.
- Branches: BNE then BEQ → BRANCH state drives `alu_op`=01 with `funct_out`=010 and 110 respectively, `pc_write_cond`=1, `pc_source`=01; 3 cycles each.
- Halt and reset: HALT → `halted`=1, count frozen for 10 cycles; then assert `reset` mid-cycle → FETCH and count 0 asynchronously, before the next edge.
- Store wait plus mid-wait reset: SW with `mem_ready` low in MEM_WRITE, `reset` pulsed there → `mem_write` drops immediately, no retire.
- Wrap: CNT_W=4, 16 J instructions → `instr_count` goes 15→0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle 16-bit processor control path.
//   - opcode constants (IR[15:13])
//   - ALUOp codes handed to the ALU control decoder
//   - alu_src_b / pc_source mux encodings
//   - main control state enum and the control-word struct
//   - ctrlFor(): Moore decode of a state into its control word
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Opcode field IR[15:13]
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_BNE   = 3'b100;
    localparam logic [2:0] OP_ADDI  = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // ALUOp codes consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ADDI   = 2'b11;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Branch comparisons the ALU control decoder understands
    localparam logic [2:0] FUNCT_BNE = 3'b010;
    localparam logic [2:0] FUNCT_BEQ = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_ALU_WB    = 4'd7,
        S_IMM_EXEC  = 4'd8,
        S_IMM_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    // fetch_gate marks the one state whose pc_write/ir_write must also
    // wait for mem_ready; it never leaves the control unit.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [2:0] funct_out;
        logic       halted;
        logic       fetch_gate;
    } ctrl_t;

    // Every field starts at zero so each state only lists what it drives.
    function automatic ctrl_t ctrlFor(input state_t s,
                                      input logic [2:0] op,
                                      input logic [2:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.alu_src_b  = SRCB_ONE;
                c.alu_op     = ALUOP_ADD;
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.fetch_gate = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_BRANCH;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALUOP_RTYPE;
                c.funct_out = fn;
            end
            S_ALU_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_op    = ALUOP_RTYPE;
                c.funct_out = fn;
            end
            S_IMM_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADDI;
            end
            S_IMM_WB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REGB;
                c.alu_op        = ALUOP_BRANCH;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.funct_out     = (op == OP_BNE) ? FUNCT_BNE : FUNCT_BEQ;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            S_HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the main control unit and the datapath.
//   IR side     : opcode, funct_in
//   memory side : mem_ready
//   datapath    : enables/selects, alu_op/funct_out, halted, instr_count
// Modports: master = control unit, slave = datapath/memory side.
// ----------------------------------------------------------------------------
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       opcode;
    logic [2:0]       funct_in;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [1:0]       alu_op;
    logic [2:0]       funct_out;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct_in, mem_ready,
        output pc_write, pc_write_cond, ir_write, mem_read, mem_write,
               i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, pc_source, alu_op, funct_out, halted, instr_count
    );

    modport slave (
        output opcode, funct_in, mem_ready,
        input  pc_write, pc_write_cond, ir_write, mem_read, mem_write,
               i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, pc_source, alu_op, funct_out, halted, instr_count
    );

endinterface

// File: rtl/retire_counter.sv
// ----------------------------------------------------------------------------
// retire_counter
// Wrapping count of retired instructions.
//   clock : system clock, rising edge
//   clear : asynchronous active-high clear
//   inc   : add one on this edge
//   count : current value, wraps 2^CNT_W-1 -> 0
// ----------------------------------------------------------------------------
module retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Natural binary overflow provides the wrap back to zero.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Moore main control FSM for the multicycle 16-bit processor.
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset, returns to FETCH
//   bus   : multicycle_control_if.master (IR fields, mem_ready in;
//           datapath enables/selects, alu_op/funct_out, halted,
//           instr_count out)
// ----------------------------------------------------------------------------
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    // Control word seen immediately under reset.
    localparam ctrl_t FETCH_CTRL = ctrlFor(S_FETCH, OP_RTYPE, 3'b000);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  r_ctrl;
    logic   w_retire;

    // Next-state decode. Only FETCH, MEM_READ and MEM_WRITE look at
    // mem_ready; every other state ignores it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:     w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      w_next_state = S_EXEC;
                    OP_LW, OP_SW:  w_next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: w_next_state = S_BRANCH;
                    OP_ADDI:       w_next_state = S_IMM_EXEC;
                    OP_J:          w_next_state = S_JUMP;
                    default:       w_next_state = S_HALT;
                endcase
            end
            S_MEM_ADDR:  w_next_state = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next_state = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next_state = S_FETCH;
            S_MEM_WRITE: w_next_state = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC:      w_next_state = S_ALU_WB;
            S_ALU_WB:    w_next_state = S_FETCH;
            S_IMM_EXEC:  w_next_state = S_IMM_WB;
            S_IMM_WB:    w_next_state = S_FETCH;
            S_BRANCH:    w_next_state = S_FETCH;
            S_JUMP:      w_next_state = S_FETCH;
            S_HALT:      w_next_state = S_HALT;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    // A store only finishes once memory accepts the write.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEM_WB, S_ALU_WB, S_IMM_WB, S_BRANCH, S_JUMP: w_retire = 1'b1;
            S_MEM_WRITE: w_retire = bus.mem_ready;
            default:     w_retire = 1'b0;
        endcase
    end

    // State and control word are registered together: the control word is
    // decoded from the state being entered, so outputs are a pure function
    // of the current state. funct_in/opcode are stable from DECODE onward,
    // so capturing them on entry to EXEC/BRANCH is equivalent to decoding
    // them live.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= FETCH_CTRL;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= ctrlFor(w_next_state, bus.opcode, bus.funct_in);
        end
    end

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clock (clock),
        .clear (reset),
        .inc   (w_retire),
        .count (bus.instr_count)
    );

    // FETCH may only load IR and advance PC once memory has the word.
    assign bus.pc_write      = r_ctrl.pc_write & (~r_ctrl.fetch_gate | bus.mem_ready);
    assign bus.ir_write      = r_ctrl.ir_write & bus.mem_ready;
    assign bus.pc_write_cond = r_ctrl.pc_write_cond;
    assign bus.mem_read      = r_ctrl.mem_read;
    assign bus.mem_write     = r_ctrl.mem_write;
    assign bus.i_or_d        = r_ctrl.i_or_d;
    assign bus.reg_write     = r_ctrl.reg_write;
    assign bus.reg_dst       = r_ctrl.reg_dst;
    assign bus.mem_to_reg    = r_ctrl.mem_to_reg;
    assign bus.alu_src_a     = r_ctrl.alu_src_a;
    assign bus.alu_src_b     = r_ctrl.alu_src_b;
    assign bus.pc_source     = r_ctrl.pc_source;
    assign bus.alu_op        = r_ctrl.alu_op;
    assign bus.funct_out     = r_ctrl.funct_out;
    assign bus.halted        = r_ctrl.halted;

endmodule
